// File: rtl/mdata_gen.sv
// Multi-channel burst pattern generator with per-channel valid/ready handshake.
// Define MDATA_GEN_LFSR_EN to build the Galois LFSR pattern for mode 1; otherwise mode 1 is a counter.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | waiting for start; outputs idle, start latches configuration
// S_RUN   | offering words on every channel until burst_len or stop
// S_DRAIN | stop seen; only words already offered may still transfer
// S_DONE  | one-cycle completion pulse, then back to S_IDLE
module mdata_gen #(
  parameter int                WIDTH     = 8,
  parameter int                CHANNELS  = 2,
  parameter logic [WIDTH-1:0]  LFSR_TAPS = WIDTH'('hB8)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        stop,
  input  logic [1:0]                  mode,
  input  logic [WIDTH-1:0]            seed,
  input  logic [15:0]                 burst_len,
  output logic [CHANNELS*WIDTH-1:0]   dout,
  output logic [CHANNELS-1:0]         dvalid,
  input  logic [CHANNELS-1:0]         dready,
  output logic                        busy,
  output logic                        done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] M_COUNT = 2'd0;
`ifdef MDATA_GEN_LFSR_EN
  localparam logic [1:0] M_LFSR  = 2'd1;
`endif
  localparam logic [1:0] M_CONST = 2'd2;
  localparam logic [1:0] M_WALK  = 2'd3;

  state_t                          state;
  logic [1:0]                      mode_q;
  logic [15:0]                     len_q;
  logic [CHANNELS-1:0][WIDTH-1:0]  val;
  logic [CHANNELS-1:0][15:0]       cnt;

  logic [CHANNELS-1:0]             xfer;
  logic [CHANNELS-1:0]             fin;
  logic [CHANNELS-1:0]             dvalid_run_nxt;
  logic [CHANNELS-1:0]             dvalid_drain_nxt;
  logic [CHANNELS-1:0][15:0]       cnt_inc;

  function automatic logic [WIDTH-1:0] init_val(input logic [1:0] m,
                                                input logic [WIDTH-1:0] s,
                                                input int n);
    logic [WIDTH-1:0] v;
    v = s + WIDTH'(n);
    case (m)
`ifdef MDATA_GEN_LFSR_EN
      M_LFSR: begin
        v = s ^ WIDTH'(n);
        if (v == '0) v = WIDTH'(1);
      end
`endif
      M_CONST: v = s;
      M_WALK:  v = WIDTH'(1) << (n % WIDTH);
      default: v = s + WIDTH'(n);
    endcase
    return v;
  endfunction

  function automatic logic [WIDTH-1:0] next_val(input logic [1:0] m,
                                                input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = v + WIDTH'(1);
    case (m)
`ifdef MDATA_GEN_LFSR_EN
      M_LFSR:  r = (v >> 1) ^ (v[0] ? LFSR_TAPS : '0);
`endif
      M_CONST: r = v;
      M_WALK:  r = {v[WIDTH-2:0], v[WIDTH-1]};
      default: r = v + WIDTH'(1);
    endcase
    return r;
  endfunction

  // fin marks the transfer that delivers a channel's last word of a bounded burst
  always_comb begin
    xfer             = dvalid & dready;
    fin              = '0;
    cnt_inc          = cnt;
    for (int n = 0; n < CHANNELS; n++) begin
      if (cnt[n] != 16'hFFFF) cnt_inc[n] = cnt[n] + 16'd1;
      fin[n] = xfer[n] && (len_q != 16'd0) && (cnt[n] + 16'd1 == len_q);
    end
    dvalid_run_nxt   = dvalid & ~fin;
    dvalid_drain_nxt = dvalid & ~xfer;
  end

  assign busy = (state != S_IDLE);
  assign dout = val;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      mode_q <= M_COUNT;
      len_q  <= '0;
      val    <= '0;
      cnt    <= '0;
      dvalid <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      for (int n = 0; n < CHANNELS; n++) begin
        if (xfer[n]) begin
          val[n] <= next_val(mode_q, val[n]);
          cnt[n] <= cnt_inc[n];
        end
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            mode_q <= mode;
            len_q  <= burst_len;
            for (int n = 0; n < CHANNELS; n++) begin
              val[n] <= init_val(mode, seed, n);
              cnt[n] <= '0;
            end
            dvalid <= '1;
            state  <= S_RUN;
          end
        end

        S_RUN: begin
          // a stop landing on the last outstanding transfer skips DRAIN
          if (stop) begin
            dvalid <= dvalid_drain_nxt;
            if (dvalid_drain_nxt == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_DRAIN;
            end
          end else begin
            dvalid <= dvalid_run_nxt;
            if (dvalid_run_nxt == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end

        S_DRAIN: begin
          dvalid <= dvalid_drain_nxt;
          if (dvalid_drain_nxt == '0) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state  <= S_IDLE;
          dvalid <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdata_gen.sv
// Directed bench for mdata_gen (WIDTH=8, CHANNELS=2); inputs driven and outputs sampled on the falling edge.
module tb_mdata_gen;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stop;
  logic [1:0]  mode;
  logic [7:0]  seed;
  logic [15:0] burst_len;
  logic [15:0] dout;
  logic [1:0]  dvalid;
  logic [1:0]  dready;
  logic        busy;
  logic        done;

  int n_chk  = 0;
  int n_fail = 0;

  mdata_gen #(.WIDTH(8), .CHANNELS(2), .LFSR_TAPS(8'hB8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .seed      (seed),
    .burst_len (burst_len),
    .dout      (dout),
    .dvalid    (dvalid),
    .dready    (dready),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic go(input logic [1:0] m, input logic [7:0] s, input logic [15:0] len,
                    input logic [1:0] rdy);
    mode = m; seed = s; burst_len = len; dready = rdy; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'd0; seed = 8'h00;
    burst_len = 16'd0; dready = 2'b00;
    tick(); tick();
    chk("reset_dvalid", 32'(dvalid), 32'h0);
    chk("reset_dout",   32'(dout),   32'h0);
    chk("reset_busy",   32'(busy),   32'h0);
    chk("reset_done",   32'(done),   32'h0);
    rst = 1'b0;
    tick();
    chk("idle_stop_ignored_busy", 32'(busy), 32'h0);

    // counter with wrap; config inputs scrambled after the start is latched
    go(2'd0, 8'hFE, 16'd4, 2'b11);
    mode = 2'd3; seed = 8'h00; burst_len = 16'd1;
    for (int k = 0; k < 4; k++) begin
      chk("cnt_ch0",    32'(dout[7:0]),  32'(8'(8'hFE + k)));
      chk("cnt_ch1",    32'(dout[15:8]), 32'(8'(8'hFF + k)));
      chk("cnt_dvalid", 32'(dvalid),     32'h3);
      chk("cnt_nodone", 32'(done),       32'h0);
      if (k == 1) start = 1'b1;
      tick();
      start = 1'b0;
    end
    chk("cnt_done_pulse", 32'(done),   32'h1);
    chk("cnt_dvalid_off", 32'(dvalid), 32'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("cnt_done_once",   32'(done), 32'h0);
    chk("cnt_busy_after",  32'(busy), 32'h0);
    tick();
    chk("start_in_done_ignored", 32'(busy), 32'h0);

    // walking one with channel 1 stalled for five cycles
    go(2'd3, 8'h00, 16'd3, 2'b01);
    for (int i = 0; i < 5; i++) begin
      chk("walk_ch1_hold",   32'(dout[15:8]), 32'h02);
      chk("walk_ch1_valid",  32'(dvalid[1]),  32'h1);
      chk("walk_ch0_valid",  32'(dvalid[0]),  (i < 3) ? 32'h1 : 32'h0);
      if (i < 3) chk("walk_ch0_data", 32'(dout[7:0]), 32'(8'(8'h01 << i)));
      chk("walk_no_done",    32'(done),       32'h0);
      tick();
    end
    dready = 2'b11;
    chk("walk_ch1_w0", 32'(dout[15:8]), 32'h02);
    tick();
    chk("walk_ch1_w1", 32'(dout[15:8]), 32'h04);
    chk("walk_no_done_mid", 32'(done), 32'h0);
    tick();
    chk("walk_ch1_w2", 32'(dout[15:8]), 32'h08);
    chk("walk_busy", 32'(busy), 32'h1);
    tick();
    chk("walk_done",   32'(done),   32'h1);
    chk("walk_dvalid", 32'(dvalid), 32'h0);
    tick();
    chk("walk_idle",   32'(busy),   32'h0);

    // unbounded constant burst, stop while stalled, then drain
    go(2'd2, 8'h5A, 16'd0, 2'b00);
    chk("const_data",  32'(dout),   32'h5A5A);
    chk("const_valid", 32'(dvalid), 32'h3);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("drain_valid_held", 32'(dvalid), 32'h3);
    chk("drain_data_held",  32'(dout),   32'h5A5A);
    chk("drain_no_done",    32'(done),   32'h0);
    chk("drain_busy",       32'(busy),   32'h1);
    tick();
    chk("drain_still_held", 32'(dvalid), 32'h3);
    dready = 2'b11;
    tick();
    dready = 2'b00;
    chk("drain_done",   32'(done),   32'h1);
    chk("drain_dvalid", 32'(dvalid), 32'h0);
    tick();
    chk("drain_idle",   32'(busy),   32'h0);
    chk("drain_done_1cyc", 32'(done), 32'h0);

    // stop coinciding with the final transfer goes straight to DONE
    go(2'd0, 8'h20, 16'd2, 2'b11);
    tick();
    chk("stopfin_data", 32'(dout), 32'h2221);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stopfin_done",   32'(done),   32'h1);
    chk("stopfin_dvalid", 32'(dvalid), 32'h0);
    tick();
    chk("stopfin_idle",   32'(busy),   32'h0);

    // reset mid-burst discards the burst
    go(2'd0, 8'h10, 16'd8, 2'b11);
    chk("rst_pre_data", 32'(dout), 32'h1110);
    tick(); tick();
    chk("rst_after2", 32'(dout), 32'h1312);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_dvalid", 32'(dvalid), 32'h0);
    chk("rst_busy",   32'(busy),   32'h0);
    chk("rst_done",   32'(done),   32'h0);
    chk("rst_dout",   32'(dout),   32'h0);
    tick();
    chk("rst_no_late_done", 32'(done), 32'h0);
    go(2'd0, 8'h10, 16'd8, 2'b00);
    chk("rst_restart", 32'(dout), 32'h1110);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // mode 1: counter unless the LFSR build is selected
    go(2'd1, 8'h10, 16'd2, 2'b11);
`ifdef MDATA_GEN_LFSR_EN
    chk("m1_w0", 32'(dout), 32'h1110);
    tick();
    chk("m1_w1", 32'(dout), 32'hB008);
`else
    chk("m1_w0", 32'(dout), 32'h1110);
    tick();
    chk("m1_w1", 32'(dout), 32'h1211);
`endif
    tick();
    chk("m1_done", 32'(done), 32'h1);
    tick();

`ifdef MDATA_GEN_LFSR_EN
    go(2'd1, 8'h00, 16'd3, 2'b11);
    chk("lfsr_w0", 32'(dout[7:0]), 32'h01);
    tick();
    chk("lfsr_w1", 32'(dout[7:0]), 32'hB8);
    tick();
    chk("lfsr_w2", 32'(dout[7:0]), 32'h5C);
    tick();
    chk("lfsr_done", 32'(done), 32'h1);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
